// File: rtl/sprite_bank_scheduler.sv
// Sprite RAM double-buffer scheduler: loader grants, frame-start swaps, beam-to-address read path.
// Build option: define SPRITE_SCALE2X_EN to show each sprite pixel as a 2x2 block.
module sprite_bank_scheduler #(
  parameter int         SPRITEWIDTH         = 64,
  parameter int         NUMPIXELS           = 4096,
  parameter logic [9:0] SLOT0_X             = 10'd100,
  parameter logic [9:0] SLOT0_Y             = 10'd200,
  parameter logic [9:0] SLOT1_X             = 10'd400,
  parameter logic [9:0] SLOT1_Y             = 10'd100,
  parameter int         LOAD_TIMEOUT_FRAMES = 8,
  localparam int        AW                  = $clog2(NUMPIXELS)
) (
  input  logic          vgaclk,
  input  logic          reset_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          frame_start,
  input  logic          load_req,
  input  logic          load_slot,
  input  logic          load_done,
  output logic          load_grant,
  output logic [1:0]    wr_bank,
  output logic          busy,
  output logic          load_aborted,
  output logic [AW-1:0] rd_addr,
  output logic [1:0]    rd_bank,
  output logic          pix_valid,
  output logic          pix_slot
);

`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 1;
`else
  localparam int SC = 0;
`endif
  localparam int          SH       = $clog2(SPRITEWIDTH);
  localparam logic [10:0] EXT      = 11'(SPRITEWIDTH << SC);
  localparam logic [3:0]  TMO_LAST = 4'(LOAD_TIMEOUT_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, PEND} state_t;

  state_t        state_q;
  logic          slot_q;
  logic [1:0]    front_q;
  logic [3:0]    tmo_q;

  logic [10:0]   xe, ye, s0x, s0y, s1x, s1y;
  logic          hit0, hit1;
  logic [9:0]    dx0, dy0, dx1, dy1;
  logic [AW-1:0] addr0, addr1;
  logic [AW-1:0] rd_addr_d;
  logic [1:0]    rd_bank_d;
  logic          pix_valid_d, pix_slot_d;

  // 11-bit compares keep the upper bound from wrapping near x/y = 1023
  assign xe   = {1'b0, x};
  assign ye   = {1'b0, y};
  assign s0x  = {1'b0, SLOT0_X};
  assign s0y  = {1'b0, SLOT0_Y};
  assign s1x  = {1'b0, SLOT1_X};
  assign s1y  = {1'b0, SLOT1_Y};
  assign hit0 = (xe >= s0x) && (xe < s0x + EXT) &&
                (ye >= s0y) && (ye < s0y + EXT);
  assign hit1 = (xe >= s1x) && (xe < s1x + EXT) &&
                (ye >= s1y) && (ye < s1y + EXT);

  assign dx0   = x - SLOT0_X;
  assign dy0   = y - SLOT0_Y;
  assign dx1   = x - SLOT1_X;
  assign dy1   = y - SLOT1_Y;
  assign addr0 = AW'((({2'b0, dy0} >> SC) << SH) + ({2'b0, dx0} >> SC));
  assign addr1 = AW'((({2'b0, dy1} >> SC) << SH) + ({2'b0, dx1} >> SC));

  always_comb begin
    rd_addr_d   = '0;
    rd_bank_d   = 2'b00;
    pix_valid_d = 1'b0;
    pix_slot_d  = 1'b0;
    unique case (1'b1)
      hit0: begin
        rd_addr_d   = addr0;
        rd_bank_d   = {1'b0, front_q[0]};
        pix_valid_d = 1'b1;
      end
      hit1 && !hit0: begin
        rd_addr_d   = addr1;
        rd_bank_d   = {1'b1, front_q[1]};
        pix_valid_d = 1'b1;
        pix_slot_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge vgaclk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      slot_q       <= 1'b0;
      front_q      <= 2'b00;
      tmo_q        <= 4'd0;
      load_grant   <= 1'b0;
      wr_bank      <= 2'b00;
      busy         <= 1'b0;
      load_aborted <= 1'b0;
      rd_addr      <= '0;
      rd_bank      <= 2'b00;
      pix_valid    <= 1'b0;
      pix_slot     <= 1'b0;
    end else begin
      load_aborted <= 1'b0;
      rd_addr      <= rd_addr_d;
      rd_bank      <= rd_bank_d;
      pix_valid    <= pix_valid_d;
      pix_slot     <= pix_slot_d;
      unique case (state_q)
        IDLE: if (load_req) begin
          state_q    <= LOAD;
          slot_q     <= load_slot;
          wr_bank    <= {load_slot, ~front_q[load_slot]};
          load_grant <= 1'b1;
          busy       <= 1'b1;
          tmo_q      <= 4'd0;
        end
        LOAD: begin
          if (load_done && frame_start) begin
            front_q[slot_q] <= ~front_q[slot_q];
            state_q         <= IDLE;
            load_grant      <= 1'b0;
            busy            <= 1'b0;
          end else if (load_done) begin
            state_q    <= PEND;
            load_grant <= 1'b0;
          end else if (frame_start) begin
            if (tmo_q == TMO_LAST) begin
              state_q      <= IDLE;
              load_grant   <= 1'b0;
              busy         <= 1'b0;
              load_aborted <= 1'b1;
            end else begin
              tmo_q <= tmo_q + 4'd1;
            end
          end
        end
        PEND: if (frame_start) begin
          front_q[slot_q] <= ~front_q[slot_q];
          state_q         <= IDLE;
          busy            <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_bank_scheduler.sv
// Directed bench for sprite_bank_scheduler: read-path scoreboard plus FSM status checks.
module tb_sprite_bank_scheduler;

  logic        vgaclk = 1'b0;
  logic        reset_n;
  logic [9:0]  x, y;
  logic        frame_start, load_req, load_slot, load_done;
  logic        load_grant, busy, load_aborted, pix_valid, pix_slot;
  logic [1:0]  wr_bank, rd_bank;
  logic [11:0] rd_addr;

  int vectors = 0;
  int errs    = 0;
  logic [15:0] sb_q[$];

  always #5 vgaclk = ~vgaclk;

  sprite_bank_scheduler dut (
    .vgaclk       (vgaclk),
    .reset_n      (reset_n),
    .x            (x),
    .y            (y),
    .frame_start  (frame_start),
    .load_req     (load_req),
    .load_slot    (load_slot),
    .load_done    (load_done),
    .load_grant   (load_grant),
    .wr_bank      (wr_bank),
    .busy         (busy),
    .load_aborted (load_aborted),
    .rd_addr      (rd_addr),
    .rd_bank      (rd_bank),
    .pix_valid    (pix_valid),
    .pix_slot     (pix_slot)
  );

  task automatic step();
    @(posedge vgaclk);
    #1;
  endtask

  // status vector: {load_grant, wr_bank, busy, load_aborted}
  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {load_grant, wr_bank, busy, load_aborted};
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic rd_pop(input string tag);
    logic [15:0] obs, exp;
    obs = {pix_valid, pix_slot, rd_bank, rd_addr};
    vectors++;
    if (sb_q.size() == 0) begin
      errs++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
        errs++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // exp = {valid, slot, bank, addr}
  task automatic rd(input string tag, input int xi, input int yi,
                    input logic v, input logic s, input logic [1:0] b,
                    input int a);
    x = 10'(xi);
    y = 10'(yi);
    sb_q.push_back({v, s, b, 12'(a)});
    step();
    rd_pop(tag);
    x = 10'd0;
    y = 10'd0;
  endtask

  initial begin
    reset_n = 1'b0;
    x = 10'd0; y = 10'd0;
    frame_start = 1'b0; load_req = 1'b0;
    load_slot = 1'b0; load_done = 1'b0;
    step(); step();
    reset_n = 1'b1;
    chk("reset_status", 5'b0_00_0_0);
    sb_q.push_back(16'h0000);
    rd_pop("reset_read");

    rd("s0_origin", 100, 200, 1'b1, 1'b0, 2'b00, 0);
    rd("s0_corner", 163, 263, 1'b1, 1'b0, 2'b00, 4095);
    rd("s0_x_past", 164, 263, 1'b0, 1'b0, 2'b00, 0);
    rd("s0_x_below", 99, 200, 1'b0, 1'b0, 2'b00, 0);
    rd("s0_y_past", 120, 264, 1'b0, 1'b0, 2'b00, 0);
    rd("s1_origin", 400, 100, 1'b1, 1'b1, 2'b10, 0);
    rd("s1_mid", 420, 110, 1'b1, 1'b1, 2'b10, 660);
    rd("far_edge", 1023, 1023, 1'b0, 1'b0, 2'b00, 0);

    load_done = 1'b1; step(); load_done = 1'b0;
    chk("done_in_idle", 5'b0_00_0_0);

    load_req = 1'b1; load_slot = 1'b1; step();
    load_req = 1'b0; load_slot = 1'b0;
    chk("grant_s1", 5'b1_11_1_0);
    load_done = 1'b1; step(); load_done = 1'b0;
    chk("pend_s1", 5'b0_11_1_0);
    load_req = 1'b1; step(); load_req = 1'b0;
    chk("req_in_pend", 5'b0_11_1_0);
    step(); step();
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("swap_s1", 5'b0_11_0_0);
    rd("s1_swapped", 400, 100, 1'b1, 1'b1, 2'b11, 0);
    rd("s0_unswapped", 100, 200, 1'b1, 1'b0, 2'b00, 0);

    load_req = 1'b1; load_slot = 1'b0; step(); load_req = 1'b0;
    chk("grant_s0", 5'b1_01_1_0);
    load_done = 1'b1; frame_start = 1'b1; step();
    load_done = 1'b0; frame_start = 1'b0;
    chk("swap_now_s0", 5'b0_01_0_0);
    rd("s0_swapped", 100, 200, 1'b1, 1'b0, 2'b01, 0);

    load_req = 1'b1; load_slot = 1'b1; step(); load_req = 1'b0;
    chk("grant_tmo", 5'b1_10_1_0);
    for (int i = 1; i <= 8; i++) begin
      frame_start = 1'b1; step(); frame_start = 1'b0;
      if (i < 8) chk("tmo_wait", 5'b1_10_1_0);
      else       chk("tmo_abort", 5'b0_10_0_1);
      step();
      chk("tmo_gap", {i < 8, 2'b10, i < 8, 1'b0});
    end
    rd("s1_after_abort", 400, 100, 1'b1, 1'b1, 2'b11, 0);

    load_req = 1'b1; load_slot = 1'b0; step(); load_req = 1'b0;
    chk("grant_pre_rst", 5'b1_00_1_0);
    x = 10'd100; y = 10'd200;
    reset_n = 1'b0; step(); reset_n = 1'b1;
    chk("rst_mid_load", 5'b0_00_0_0);
    sb_q.push_back(16'h0000);
    rd_pop("rst_mid_read");
    rd("s0_front_rst", 100, 200, 1'b1, 1'b0, 2'b00, 0);
    rd("s1_front_rst", 400, 100, 1'b1, 1'b1, 2'b10, 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("no_swap_rst", 5'b0_00_0_0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/sprite_bank_scheduler.md
# sprite_bank_scheduler

Double-buffer controller for the sprite pixel RAMs, in the `vgaclk` domain between the SPI sprite loader and the VGA colour lookup. It owns four physical 4096×4-bit banks: two on-screen slots, each with a front and a back buffer. It grants the loader one back buffer at a time and swaps front/back only at frame start, so a half-written sprite is never displayed. It also turns beam coordinates into registered read addresses for whichever slot covers the current pixel.

## Interface
- `SPRITEWIDTH`, 64: sprite edge in pixels; always a power of two.
- `NUMPIXELS`, 4096: words per bank; equals `SPRITEWIDTH`².
- `SLOT0_X`, 10'd100 / `SLOT0_Y`, 10'd200: top-left corner of slot 0 on screen.
- `SLOT1_X`, 10'd400 / `SLOT1_Y`, 10'd100: top-left corner of slot 1 on screen.
- `LOAD_TIMEOUT_FRAMES`, 8: number of frame starts allowed in LOAD before the load is aborted.
- `vgaclk` in 1: the only clock; every register uses its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `x`, `y` in 10 each: beam coordinates.
- `frame_start` in 1: one-cycle pulse at the start of vertical blanking.
- `load_req` in 1: one-cycle pulse from the loader, already synchronised into `vgaclk`.
- `load_slot` in 1: target slot, sampled with `load_req`.
- `load_done` in 1: one-cycle pulse, sent after the last pixel is written.
- `load_grant` out 1: high while the loader may write `wr_bank`.
- `wr_bank` out 2: physical bank to write, encoded {slot, buffer}.
- `busy` out 1: high in any state other than IDLE.
- `load_aborted` out 1: one-cycle pulse when a load times out.
- `rd_addr` out 12: pixel address within the bank.
- `rd_bank` out 2: physical bank to read, encoded {slot, buffer}.
- `pix_valid` out 1: the current pixel lies inside a slot.
- `pix_slot` out 1: slot supplying the current pixel.

## Operation
- Per-slot state bit `front[s]` names the displayed buffer. The back buffer of slot s is `~front[s]`.
- FSM states:
  - IDLE → LOAD on `load_req`. Latches `slot_r = load_slot`; `wr_bank = {slot_r, ~front[slot_r]}`; `load_grant = 1`.
  - LOAD → PEND on `load_done`; `load_grant` drops.
  - LOAD → SWAP-now if `load_done` and `frame_start` arrive in the same cycle: `front[slot_r]` toggles on that edge and the FSM goes straight to IDLE.
  - PEND → IDLE on `frame_start`; `front[slot_r]` toggles on the same edge.
  - LOAD → IDLE with no toggle when the timeout counter reaches `LOAD_TIMEOUT_FRAMES`. `load_aborted` pulses and `load_grant` drops.
- Timeout counter: 4 bits, cleared on entry to LOAD, increments on each `frame_start` while in LOAD.
- `load_req` outside IDLE is ignored and is not queued.
- `load_done` outside LOAD is ignored.
- `wr_bank` holds its value outside LOAD; the RAM write enable is gated by `load_grant`.
- Read path:
  - Slot s is hit when `SLOTs_X ≤ x < SLOTs_X+SPRITEWIDTH` and `SLOTs_Y ≤ y < SLOTs_Y+SPRITEWIDTH`. Compare in 11 bits so the upper bound cannot wrap.
  - Slot 0 wins where the slots overlap.
  - On a hit: `rd_addr = (y−SLOTs_Y)·SPRITEWIDTH + (x−SLOTs_X)`, implemented as a shift, truncated to 12 bits. `rd_bank = {s, front[s]}`, `pix_valid = 1`, `pix_slot = s`.
  - On a miss: `rd_addr = 0`, `rd_bank = 0`, `pix_valid = 0`, `pix_slot = 0`.
  - `rd_bank` uses the `front` value before any toggle in the same cycle.

## Timing
- Reset values: state IDLE, `front = 2'b00`, timeout counter 0. All outputs are 0.
- Reset mid-LOAD abandons the load with no swap and no `load_aborted` pulse.
- `load_grant` and `wr_bank` are valid the cycle after `load_req`.
- `load_grant` falls the cycle after `load_done`.
- The swap is visible on `rd_bank` the cycle after the `frame_start` edge that performs it.
- Read path latency is exactly 1 cycle from `x`/`y` to `rd_addr`/`rd_bank`/`pix_valid`/`pix_slot`. With the RAM's 1-cycle read, colour is 2 cycles behind the beam; the downstream stage delays its timing signals to match.

## Configuration
- `SPRITE_SCALE2X_EN` defined: each slot covers 2·`SPRITEWIDTH` square on screen, and `rd_addr = ((dy>>1)·SPRITEWIDTH) + (dx>>1)`, so every sprite pixel shows as 2×2. Hit tests use the doubled extent.
- `SPRITE_SCALE2X_EN` undefined: 1:1 mapping, `SPRITEWIDTH` square per slot.
- The FSM is identical in both builds.

## Test plan
- Reset, then `x=100,y=200` → one cycle later `rd_addr=0`, `rd_bank=2'b00`, `pix_valid=1`, `pix_slot=0`. With `x=163,y=263` → `rd_addr=4095`. With `x=164` → `pix_valid=0`.
- `load_req` with `load_slot=1` → next cycle `load_grant=1`, `wr_bank=2'b11`. `load_done`, then `frame_start` 3 cycles later → read of `x=400,y=100` returns `rd_bank=2'b11`.
- `load_done` and `frame_start` in the same cycle → `busy=0` next cycle, slot 0 front toggled.
- Hold LOAD through 8 `frame_start` pulses with no `load_done` → `load_aborted` pulses once, `front` unchanged, `busy=0`.
- `load_req` while in PEND → ignored; `wr_bank` keeps its old value and no second grant is issued.
- `reset_n=0` for one cycle mid-LOAD → all outputs 0, `front=2'b00`.
